// File: rtl/pong_pkg.sv
// pong_pkg: shared types and constants for the Pong game controller.
//   state_t          - game sequencer states (encoding is visible on o_state)
//   SCR_*/BALL_*/PAD_* - display, ball and paddle geometry defaults
//   SERVE_TICKS/WIN_PTS - serve hold length and winning score defaults
//   CENTRE_X/Y       - ball top-left position when centred on screen
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam int SCR_W       = 1024;
    localparam int SCR_H       = 768;
    localparam int BALL_SZ     = 16;
    localparam int PAD_W       = 16;
    localparam int PAD_H       = 96;
    localparam int PAD_L_X     = 32;
    localparam int PAD_R_X     = 976;
    localparam int BALL_SPD    = 4;
    localparam int SERVE_TICKS = 60;
    localparam int WIN_PTS     = 9;

    // Direction bit meanings for dx / dy.
    localparam logic DX_RIGHT = 1'b1;
    localparam logic DX_LEFT  = 1'b0;
    localparam logic DY_DOWN  = 1'b1;
    localparam logic DY_UP    = 1'b0;

    // Top-left coordinate that centres an object of 'size' within 'span'.
    function automatic logic [10:0] centre_of(input int span, input int size);
        return 11'((span - size) / 2);
    endfunction

    localparam logic [10:0] CENTRE_X = centre_of(SCR_W, BALL_SZ);
    localparam logic [10:0] CENTRE_Y = centre_of(SCR_H, BALL_SZ);

endpackage

// File: rtl/pong_ball_step.sv
// pong_ball_step: combinational one-frame ball advance.
//   x, y, dx, dy       - current ball top-left and direction
//   pad_l_y, pad_r_y   - paddle top y positions
//   nx, ny, ndx, ndy   - next position and direction
//   miss_l, miss_r     - ball left the field past the left / right paddle
// Both axes are evaluated from the current values; arithmetic is 12-bit
// so the edge comparisons cannot wrap.
module pong_ball_step
    import pong_pkg::*;
#(
    parameter int SCREEN_W   = SCR_W,
    parameter int SCREEN_H   = SCR_H,
    parameter int BALL_SIZE  = BALL_SZ,
    parameter int PADDLE_W   = PAD_W,
    parameter int PADDLE_H   = PAD_H,
    parameter int PADDLE_L_X = PAD_L_X,
    parameter int PADDLE_R_X = PAD_R_X,
    parameter int BALL_SPEED = BALL_SPD
) (
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        dx,
    input  logic        dy,
    input  logic [10:0] pad_l_y,
    input  logic [10:0] pad_r_y,
    output logic [10:0] nx,
    output logic [10:0] ny,
    output logic        ndx,
    output logic        ndy,
    output logic        miss_l,
    output logic        miss_r
);

    localparam logic [11:0] W   = 12'(SCREEN_W);
    localparam logic [11:0] H   = 12'(SCREEN_H);
    localparam logic [11:0] SZ  = 12'(BALL_SIZE);
    localparam logic [11:0] PW  = 12'(PADDLE_W);
    localparam logic [11:0] PH  = 12'(PADDLE_H);
    localparam logic [11:0] LX  = 12'(PADDLE_L_X);
    localparam logic [11:0] RX  = 12'(PADDLE_R_X);
    localparam logic [11:0] SPD = 12'(BALL_SPEED);

    logic [11:0] x12, y12, pl12, pr12;
    logic        ovl_l, ovl_r, hit_l, hit_r;

    assign x12  = {1'b0, x};
    assign y12  = {1'b0, y};
    assign pl12 = {1'b0, pad_l_y};
    assign pr12 = {1'b0, pad_r_y};

    always_comb begin
        ovl_l = (y12 + SZ > pl12) && (y12 < pl12 + PH);
        ovl_r = (y12 + SZ > pr12) && (y12 < pr12 + PH);

        ny  = y;
        ndy = dy;
        if (dy == DY_DOWN) begin
            if (y12 + SZ + SPD >= H) begin
                ny  = 11'(H - SZ);
                ndy = DY_UP;
            end else begin
                ny = 11'(y12 + SPD);
            end
        end else begin
            if (y12 <= SPD) begin
                ny  = '0;
                ndy = DY_DOWN;
            end else begin
                ny = 11'(y12 - SPD);
            end
        end

        // Hit windows only span one step in front of each paddle face, so a
        // ball already past the face can only continue to a miss.
        nx     = x;
        ndx    = dx;
        hit_l  = 1'b0;
        hit_r  = 1'b0;
        miss_l = 1'b0;
        miss_r = 1'b0;
        if (dx == DX_RIGHT) begin
            hit_r = (x12 >= RX - SZ - SPD) && (x12 <= RX - SZ) && ovl_r;
            if (hit_r) begin
                nx  = 11'(RX - SZ);
                ndx = DX_LEFT;
            end else if (x12 + SZ + SPD >= W) begin
                nx     = 11'(W - SZ);
                miss_r = 1'b1;
            end else begin
                nx = 11'(x12 + SPD);
            end
        end else begin
            hit_l = (x12 >= LX + PW) && (x12 <= LX + PW + SPD) && ovl_l;
            if (hit_l) begin
                nx  = 11'(LX + PW);
                ndx = DX_RIGHT;
            end else if (x12 <= SPD) begin
                nx     = '0;
                miss_l = 1'b1;
            end else begin
                nx = 11'(x12 - SPD);
            end
        end
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: frame-rate Pong sequencer (serve / play / point / over).
//   i_clk, i_rst          - clock, async active-high reset
//   i_animate             - one-cycle end-of-frame strobe; paces all motion
//   i_start               - start button level (used in IDLE and OVER)
//   i_paddle_l_y/_r_y     - paddle top y, sampled on animate
//   o_ball_x/_y           - ball top-left
//   o_score_l/_r          - scores
//   o_state               - state_t encoding
//   o_point               - high for the single POINT cycle
//   o_winner              - 0 left, 1 right; meaningful in OVER
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int SCREEN_W     = SCR_W,
    parameter int SCREEN_H     = SCR_H,
    parameter int BALL_SIZE    = BALL_SZ,
    parameter int PADDLE_W     = PAD_W,
    parameter int PADDLE_H     = PAD_H,
    parameter int PADDLE_L_X   = PAD_L_X,
    parameter int PADDLE_R_X   = PAD_R_X,
    parameter int BALL_SPEED   = BALL_SPD,
    parameter int SERVE_FRAMES = SERVE_TICKS,
    parameter int WIN_SCORE    = WIN_PTS
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_animate,
    input  logic        i_start,
    input  logic [10:0] i_paddle_l_y,
    input  logic [10:0] i_paddle_r_y,
    output logic [10:0] o_ball_x,
    output logic [10:0] o_ball_y,
    output logic [3:0]  o_score_l,
    output logic [3:0]  o_score_r,
    output logic [2:0]  o_state,
    output logic        o_point,
    output logic        o_winner
);

    localparam logic [10:0]    CX         = centre_of(SCREEN_W, BALL_SIZE);
    localparam logic [10:0]    CY         = centre_of(SCREEN_H, BALL_SIZE);
    localparam int             CW         = $clog2(SERVE_FRAMES + 1);
    localparam logic [CW-1:0]  SERVE_LAST = CW'(SERVE_FRAMES - 1);
    localparam logic [3:0]     WIN        = 4'(WIN_SCORE);

    state_t      state;
    logic [CW-1:0] serve_cnt;
    logic        dx, dy;
    logic        scorer;       // who scored the point being resolved: 0 left, 1 right
    logic [3:0]  scorer_pts;
    logic [10:0] nx, ny;
    logic        ndx, ndy, miss_l, miss_r;

    pong_ball_step #(
        .SCREEN_W   (SCREEN_W),
        .SCREEN_H   (SCREEN_H),
        .BALL_SIZE  (BALL_SIZE),
        .PADDLE_W   (PADDLE_W),
        .PADDLE_H   (PADDLE_H),
        .PADDLE_L_X (PADDLE_L_X),
        .PADDLE_R_X (PADDLE_R_X),
        .BALL_SPEED (BALL_SPEED)
    ) u_step (
        .x       (o_ball_x),
        .y       (o_ball_y),
        .dx      (dx),
        .dy      (dy),
        .pad_l_y (i_paddle_l_y),
        .pad_r_y (i_paddle_r_y),
        .nx      (nx),
        .ny      (ny),
        .ndx     (ndx),
        .ndy     (ndy),
        .miss_l  (miss_l),
        .miss_r  (miss_r)
    );

    assign o_state    = state;
    assign scorer_pts = scorer ? o_score_r : o_score_l;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            o_ball_x  <= CX;
            o_ball_y  <= CY;
            dx        <= DX_RIGHT;
            dy        <= DY_DOWN;
            o_score_l <= '0;
            o_score_r <= '0;
            o_point   <= 1'b0;
            o_winner  <= 1'b0;
            scorer    <= 1'b0;
            serve_cnt <= '0;
        end else begin
            o_point <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state     <= ST_SERVE;
                        serve_cnt <= '0;
                    end
                end
                ST_SERVE: begin
                    // Launch is checked against the pre-increment count, so
                    // the hold lasts exactly SERVE_FRAMES animates.
                    if (i_animate) begin
                        if (serve_cnt == SERVE_LAST) state <= ST_PLAY;
                        else                         serve_cnt <= serve_cnt + 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (i_animate) begin
                        o_ball_x <= nx;
                        o_ball_y <= ny;
                        dx       <= ndx;
                        dy       <= ndy;
                        // Score and pulse land with the POINT entry so both are
                        // visible during the POINT cycle.
                        if (miss_r) begin
                            state     <= ST_POINT;
                            o_score_l <= o_score_l + 4'd1;
                            o_point   <= 1'b1;
                            scorer    <= 1'b0;
                        end else if (miss_l) begin
                            state     <= ST_POINT;
                            o_score_r <= o_score_r + 4'd1;
                            o_point   <= 1'b1;
                            scorer    <= 1'b1;
                        end
                    end
                end
                ST_POINT: begin
                    if (scorer_pts == WIN) begin
                        state    <= ST_OVER;
                        o_winner <= scorer;
                    end else begin
                        state     <= ST_SERVE;
                        serve_cnt <= '0;
                        o_ball_x  <= CX;
                        o_ball_y  <= CY;
                        // Serve toward whoever conceded: left scorer -> move right.
                        dx        <= ~scorer;
                    end
                end
                ST_OVER: begin
                    if (i_start) begin
                        state     <= ST_SERVE;
                        serve_cnt <= '0;
                        o_score_l <= '0;
                        o_score_r <= '0;
                        o_ball_x  <= CX;
                        o_ball_y  <= CY;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
